// File: rtl/mem_load_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_unit_if
// Brief    : MEM-stage load request, data-memory read port and write-back
//            result bundle for mem_load_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_load_unit_if;
    logic        Mem_Load_Valid;
    logic [31:0] Mem_Addr;
    logic [2:0]  Mem_Funct3;
    logic [4:0]  Mem_Rd;
    logic        Dmem_Req;
    logic [31:0] Dmem_Addr;
    logic        Dmem_Ack;
    logic [31:0] Dmem_RData;
    logic        Load_Stall;
    logic [31:0] Wb_Mem_ReadData;
    logic [4:0]  Wb_Load_Rd;
    logic        Wb_Load_Valid;
    logic        Load_Misaligned;
    logic        Load_Fault;

    // Pipeline and memory side: drives the load and the memory response.
    modport master (
        output Mem_Load_Valid, Mem_Addr, Mem_Funct3, Mem_Rd, Dmem_Ack, Dmem_RData,
        input  Dmem_Req, Dmem_Addr, Load_Stall, Wb_Mem_ReadData, Wb_Load_Rd,
               Wb_Load_Valid, Load_Misaligned, Load_Fault
    );

    // Load unit side.
    modport slave (
        input  Mem_Load_Valid, Mem_Addr, Mem_Funct3, Mem_Rd, Dmem_Ack, Dmem_RData,
        output Dmem_Req, Dmem_Addr, Load_Stall, Wb_Mem_ReadData, Wb_Load_Rd,
               Wb_Load_Valid, Load_Misaligned, Load_Fault
    );
endinterface
`default_nettype wire

// File: rtl/mem_load_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_unit
// Brief    : Load-side data memory port: word-aligned req/ack read, pipeline
//            stall, lane select and sign/zero extension into write-back.
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    mem_load_unit_if.slave bus
);

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_req;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;
    logic        r_wb_valid;
    logic        r_misaligned;
    logic        r_fault;

    logic        w_f3_legal;
    logic        w_misaligned;
    logic        w_accept;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    always_comb begin
        w_f3_legal = 1'b0;
        case (bus.Mem_Funct3)
            c_F3_LB, c_F3_LH, c_F3_LW, c_F3_LBU, c_F3_LHU: w_f3_legal = 1'b1;
            default:                                       w_f3_legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes width: 01 half, 10 word.
    assign w_misaligned = ((bus.Mem_Funct3[1:0] == 2'b01) && bus.Mem_Addr[0]) ||
                          ((bus.Mem_Funct3[1:0] == 2'b10) && (bus.Mem_Addr[1:0] != 2'b00));

    assign w_accept = (r_state == S_IDLE) && bus.Mem_Load_Valid && w_f3_legal && !w_misaligned;

    always_comb begin
        w_byte = bus.Dmem_RData[7:0];
        case (r_off)
            2'd0:    w_byte = bus.Dmem_RData[7:0];
            2'd1:    w_byte = bus.Dmem_RData[15:8];
            2'd2:    w_byte = bus.Dmem_RData[23:16];
            default: w_byte = bus.Dmem_RData[31:24];
        endcase
    end

    assign w_half = r_off[1] ? bus.Dmem_RData[31:16] : bus.Dmem_RData[15:0];

    always_comb begin
        w_load_data = bus.Dmem_RData;
        case (r_funct3)
            c_F3_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_F3_LBU: w_load_data = {24'd0, w_byte};
            c_F3_LHU: w_load_data = {16'd0, w_half};
            default:  w_load_data = bus.Dmem_RData;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_off        <= '0;
            r_funct3     <= '0;
            r_rd         <= '0;
            r_req        <= 1'b0;
            r_dmem_addr  <= '0;
            r_wb_data    <= '0;
            r_wb_rd      <= '0;
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Mem_Load_Valid) begin
                        if (!w_f3_legal) begin
                            r_fault <= 1'b1;
                        end else if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                        end else begin
                            r_off       <= bus.Mem_Addr[1:0];
                            r_funct3    <= bus.Mem_Funct3;
                            r_rd        <= bus.Mem_Rd;
                            r_dmem_addr <= {bus.Mem_Addr[31:2], 2'b00};
                            r_req       <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (bus.Dmem_Ack) begin
                        r_wb_data  <= w_load_data;
                        r_wb_rd    <= r_rd;
                        r_wb_valid <= 1'b1;
                        r_req      <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_req     <= 1'b0;
                        r_wb_data <= '0;
                        r_fault   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign bus.Load_Stall      = reset_n && ((r_state == S_WAIT) || w_accept);
    assign bus.Dmem_Req        = r_req;
    assign bus.Dmem_Addr       = r_dmem_addr;
    assign bus.Wb_Mem_ReadData = r_wb_data;
    assign bus.Wb_Load_Rd      = r_wb_rd;
    assign bus.Wb_Load_Valid   = r_wb_valid;
    assign bus.Load_Misaligned = r_misaligned;
    assign bus.Load_Fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_load_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_load_unit
// Brief    : Directed self-checking bench with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_load_unit;

    localparam int unsigned c_TIMEOUT = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    exp_t sb_q[$];

    mem_load_unit_if bus();

    mem_load_unit #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one load, answers it after 'waits' WAIT cycles, and checks the
    // completion against the queued expectation. Returns in the cycle after DONE.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input int waits, input logic [31:0] exp_data,
                            output int stall_n, output int req_n);
        int   cyc;
        bit   done;
        exp_t e;
        stall_n = 0;
        req_n   = 0;
        cyc     = 0;
        done    = 0;
        sb_q.push_back('{rd: rd, data: exp_data});
        bus.Mem_Load_Valid = 1'b1;
        bus.Mem_Addr       = addr;
        bus.Mem_Funct3     = f3;
        bus.Mem_Rd         = rd;
        bus.Dmem_Ack       = 1'b0;
        #1;
        checkb("accept_stall", bus.Load_Stall, 1'b1);
        while (!done && cyc < 64) begin
            if (bus.Load_Stall) stall_n++;
            if (bus.Dmem_Req) begin
                req_n++;
                check("dmem_addr", bus.Dmem_Addr, {addr[31:2], 2'b00});
            end
            if (bus.Dmem_Req && req_n == waits + 1) begin
                bus.Dmem_Ack   = 1'b1;
                bus.Dmem_RData = rdata;
            end else begin
                bus.Dmem_Ack   = 1'b0;
                bus.Dmem_RData = $urandom;
            end
            tick();
            cyc++;
            bus.Dmem_Ack = 1'b0;
            if (bus.Wb_Load_Valid) done = 1;
        end
        checkb("done_seen", done, 1'b1);
        if (done) begin
            if (sb_q.size() == 0) begin
                check("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("wb_data", bus.Wb_Mem_ReadData, e.data);
                check("wb_rd", 32'(bus.Wb_Load_Rd), 32'(e.rd));
            end
            checkb("done_stall", bus.Load_Stall, 1'b0);
            checkb("done_req", bus.Dmem_Req, 1'b0);
            checkb("done_fault", bus.Load_Fault, 1'b0);
        end
        tick();
        bus.Mem_Load_Valid = 1'b0;
        check("wb_hold", bus.Wb_Mem_ReadData, exp_data);
        checkb("valid_pulse", bus.Wb_Load_Valid, 1'b0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        mis;
        logic        flt;
    } bad_t;

    initial begin
        int   s_n;
        int   r_n;
        int   cyc;
        bit   seen;
        bad_t bad_tab[4];
        total = 0;
        bad   = 0;
        bad_tab[0] = '{addr: 32'h0000_1002, f3: 3'b010, mis: 1'b1, flt: 1'b0};
        bad_tab[1] = '{addr: 32'h0000_2001, f3: 3'b101, mis: 1'b1, flt: 1'b0};
        bad_tab[2] = '{addr: 32'h0000_1000, f3: 3'b011, mis: 1'b0, flt: 1'b1};
        bad_tab[3] = '{addr: 32'h0000_1001, f3: 3'b110, mis: 1'b0, flt: 1'b1};

        reset_n            = 1'b0;
        bus.Mem_Load_Valid = 1'b0;
        bus.Mem_Addr       = '0;
        bus.Mem_Funct3     = '0;
        bus.Mem_Rd         = '0;
        bus.Dmem_Ack       = 1'b0;
        bus.Dmem_RData     = '0;
        tick();
        tick();
        checkb("rst_req", bus.Dmem_Req, 1'b0);
        checkb("rst_stall", bus.Load_Stall, 1'b0);
        check("rst_data", bus.Wb_Mem_ReadData, 32'h0);
        check("rst_rd", 32'(bus.Wb_Load_Rd), 32'h0);
        checkb("rst_valid", bus.Wb_Load_Valid, 1'b0);
        checkb("rst_fault", bus.Load_Fault, 1'b0);
        reset_n = 1'b1;
        tick();

        // Byte and half lanes with sign and zero extension.
        run_load(32'h0000_1003, 3'b000, 5'd5, 32'h8012_3456, 0, 32'hFFFF_FF80, s_n, r_n);
        check("lb_stall_cycles", 32'(s_n), 32'd2);
        check("lb_req_cycles", 32'(r_n), 32'd1);
        run_load(32'h0000_2002, 3'b101, 5'd6, 32'hBEEF_1234, 0, 32'h0000_BEEF, s_n, r_n);
        run_load(32'h0000_2002, 3'b001, 5'd7, 32'hBEEF_1234, 0, 32'hFFFF_BEEF, s_n, r_n);
        run_load(32'h0000_4002, 3'b000, 5'd12, 32'h007F_0000, 0, 32'h0000_007F, s_n, r_n);
        run_load(32'h0000_4000, 3'b001, 5'd13, 32'h1234_8001, 0, 32'hFFFF_8001, s_n, r_n);

        // Word with three wait states (ack on the last cycle before timeout),
        // then a back-to-back load in the cycle right after DONE.
        run_load(32'h0000_3000, 3'b010, 5'd8, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, s_n, r_n);
        check("lw_stall_cycles", 32'(s_n), 32'd5);
        check("lw_req_cycles", 32'(r_n), 32'd4);
        run_load(32'h0000_3001, 3'b100, 5'd9, 32'h0000_9A00, 1, 32'h0000_009A, s_n, r_n);
        check("b2b_stall_cycles", 32'(s_n), 32'd3);

        // Illegal funct3 and misaligned accesses: single pulse, no request.
        for (int i = 0; i < 4; i++) begin
            bus.Mem_Load_Valid = 1'b1;
            bus.Mem_Addr       = bad_tab[i].addr;
            bus.Mem_Funct3     = bad_tab[i].f3;
            bus.Mem_Rd         = 5'd3;
            #1;
            checkb("bad_stall", bus.Load_Stall, 1'b0);
            tick();
            checkb("bad_mis_pulse", bus.Load_Misaligned, bad_tab[i].mis);
            checkb("bad_fault_pulse", bus.Load_Fault, bad_tab[i].flt);
            checkb("bad_no_req", bus.Dmem_Req, 1'b0);
            bus.Mem_Load_Valid = 1'b0;
            tick();
            checkb("bad_mis_clear", bus.Load_Misaligned, 1'b0);
            checkb("bad_fault_clear", bus.Load_Fault, 1'b0);
            checkb("bad_no_req2", bus.Dmem_Req, 1'b0);
        end

        // Timeout with no ack.
        bus.Mem_Load_Valid = 1'b1;
        bus.Mem_Addr       = 32'h0000_5004;
        bus.Mem_Funct3     = 3'b010;
        bus.Mem_Rd         = 5'd10;
        bus.Dmem_Ack       = 1'b0;
        #1;
        r_n  = 0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 64) begin
            if (bus.Dmem_Req) r_n++;
            tick();
            cyc++;
            if (bus.Load_Fault) seen = 1;
        end
        bus.Mem_Load_Valid = 1'b0;
        #1;
        checkb("to_fault_seen", seen, 1'b1);
        check("to_req_cycles", 32'(r_n), 32'(c_TIMEOUT));
        checkb("to_req_low", bus.Dmem_Req, 1'b0);
        check("to_data_zero", bus.Wb_Mem_ReadData, 32'h0);
        checkb("to_no_valid", bus.Wb_Load_Valid, 1'b0);
        checkb("to_stall_low", bus.Load_Stall, 1'b0);
        tick();
        checkb("to_fault_clear", bus.Load_Fault, 1'b0);
        run_load(32'h0000_5008, 3'b010, 5'd11, 32'h1357_9BDF, 2, 32'h1357_9BDF, s_n, r_n);

        // Reset in the middle of WAIT, then a stray ack after release.
        bus.Mem_Load_Valid = 1'b1;
        bus.Mem_Addr       = 32'h0000_6000;
        bus.Mem_Funct3     = 3'b010;
        bus.Mem_Rd         = 5'd14;
        tick();
        tick();
        checkb("pre_rst_req", bus.Dmem_Req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkb("mid_rst_req", bus.Dmem_Req, 1'b0);
        checkb("mid_rst_stall", bus.Load_Stall, 1'b0);
        check("mid_rst_data", bus.Wb_Mem_ReadData, 32'h0);
        check("mid_rst_rd", 32'(bus.Wb_Load_Rd), 32'h0);
        checkb("mid_rst_valid", bus.Wb_Load_Valid, 1'b0);
        bus.Mem_Load_Valid = 1'b0;
        tick();
        reset_n        = 1'b1;
        bus.Dmem_Ack   = 1'b1;
        bus.Dmem_RData = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkb("late_ack_no_valid", bus.Wb_Load_Valid, 1'b0);
            checkb("late_ack_no_req", bus.Dmem_Req, 1'b0);
            check("late_ack_data", bus.Wb_Mem_ReadData, 32'h0);
        end
        bus.Dmem_Ack = 1'b0;
        tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
